// File: rtl/seg7_scan_capture.sv
// Capture monitor for a 4-digit multiplexed active-low 7-segment interface.
// Rebuilds hex digits and DP flags with a dwell filter and reports completed frames.
module seg7_scan_capture #(
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        AN0,
    input  logic        AN1,
    input  logic        AN2,
    input  logic        AN3,
    input  logic        CA,
    input  logic        CB,
    input  logic        CC,
    input  logic        CD,
    input  logic        CE,
    input  logic        CF,
    input  logic        CG,
    input  logic        DP,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  known,
    output logic [31:0] raw_seg,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        anode_conflict
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef struct packed {
        logic       hit;
        logic [3:0] value;
    } decode_t;

    // {CG..CA} active-low pattern to hex value; unmatched patterns decode to 0, not known.
    function automatic decode_t hex_decode(input logic [6:0] pat);
        decode_t r;
        r = '0;
        r.hit = 1'b1;
        case (pat)
            7'h40:   r.value = 4'h0;
            7'h79:   r.value = 4'h1;
            7'h24:   r.value = 4'h2;
            7'h30:   r.value = 4'h3;
            7'h19:   r.value = 4'h4;
            7'h12:   r.value = 4'h5;
            7'h02:   r.value = 4'h6;
            7'h78:   r.value = 4'h7;
            7'h00:   r.value = 4'h8;
            7'h10:   r.value = 4'h9;
            7'h08:   r.value = 4'hA;
            7'h03:   r.value = 4'hB;
            7'h46:   r.value = 4'hC;
            7'h21:   r.value = 4'hD;
            7'h06:   r.value = 4'hE;
            7'h0E:   r.value = 4'hF;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [3:0]       an_q;
    logic [7:0]       seg_q;
    logic [1:0]       idx;
    logic             sample_valid;
    logic [9:0]       tag;
    logic [9:0]       prev_tag;
    logic [CNT_W-1:0] cnt;
    logic             same_tag;
    logic             capture;
    logic             new_diff;
    decode_t          dec;

    logic [3:0][7:0]  raw_q;
    logic [3:0][3:0]  digit_q;
    logic [3:0]       dp_q;
    logic [3:0]       known_q;
    logic [3:0]       seen;
    logic             chg;
    logic             fv_q;
    logic             fc_q;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= 4'hF;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= {AN3, AN2, AN1, AN0};
            seg_q <= {DP, CG, CF, CE, CD, CC, CB, CA};
        end
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        idx          = 2'd0;
        sample_valid = 1'b0;
        case (an_q)
            4'b1110: begin idx = 2'd0; sample_valid = 1'b1; end
            4'b1101: begin idx = 2'd1; sample_valid = 1'b1; end
            4'b1011: begin idx = 2'd2; sample_valid = 1'b1; end
            4'b0111: begin idx = 2'd3; sample_valid = 1'b1; end
            default: ;
        endcase
    end

    assign anode_conflict = (an_q != 4'hF) && !sample_valid;
    assign tag            = {idx, seg_q};
    assign same_tag       = (tag == prev_tag);
    assign capture        = sample_valid && same_tag && (cnt == CNT_LAST);
    assign new_diff       = (raw_q[idx] != seg_q);
    assign dec            = hex_decode(seg_q[6:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            prev_tag <= '0;
        end else if (!sample_valid) begin
            cnt <= '0;
        end else if (same_tag) begin
            if (cnt != CNT_FULL)
                cnt <= cnt + CNT_W'(1);
        end else begin
            cnt      <= CNT_W'(1);
            prev_tag <= tag;
        end
    end

    // NOTE: the capture store is a handful of flops with defined reset values, so it is reset like any other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            raw_q   <= '1;
            digit_q <= '0;
            dp_q    <= '0;
            known_q <= '0;
            seen    <= '0;
            chg     <= 1'b0;
            fv_q    <= 1'b0;
            fc_q    <= 1'b0;
        end else begin
            fv_q <= 1'b0;
            fc_q <= 1'b0;
            if (capture) begin
                raw_q[idx]   <= seg_q;
                dp_q[idx]    <= ~seg_q[7];
                digit_q[idx] <= dec.value;
                known_q[idx] <= dec.hit;
            end
            // A capture on the frame edge seeds the next frame's seen mask and change flag.
            if (seen == 4'hF) begin
                fv_q <= 1'b1;
                fc_q <= chg;
                seen <= capture ? (4'b0001 << idx) : 4'b0000;
                chg  <= capture && new_diff;
            end else if (capture) begin
                seen[idx] <= 1'b1;
                chg       <= chg | new_diff;
            end
        end
    end

    assign digits        = digit_q;
    assign dp            = dp_q;
    assign known         = known_q;
    assign raw_seg       = raw_q;
    assign frame_valid   = fv_q;
    assign frame_changed = fc_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with STABLE_CYCLES=4.
// Pins are driven and outputs sampled on the falling edge; pulses are counted by a monitor.
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        AN0, AN1, AN2, AN3;
    logic        CA, CB, CC, CD, CE, CF, CG, DP;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  known;
    logic [31:0] raw_seg;
    logic        frame_valid;
    logic        frame_changed;
    logic        anode_conflict;

    int n_checks = 0;
    int n_errors = 0;
    int fv_cnt   = 0;
    int fc_cnt   = 0;
    int ac_cnt   = 0;

    seg7_scan_capture #(
        .STABLE_CYCLES(4),
        .CNT_W        (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .AN0           (AN0),
        .AN1           (AN1),
        .AN2           (AN2),
        .AN3           (AN3),
        .CA            (CA),
        .CB            (CB),
        .CC            (CC),
        .CD            (CD),
        .CE            (CE),
        .CF            (CF),
        .CG            (CG),
        .DP            (DP),
        .digits        (digits),
        .dp            (dp),
        .known         (known),
        .raw_seg       (raw_seg),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .anode_conflict(anode_conflict)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid)    fv_cnt++;
        if (frame_changed)  fc_cnt++;
        if (anode_conflict) ac_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input logic dp_lit, input int n);
        {AN3, AN2, AN1, AN0} = an;
        {CG, CF, CE, CD, CC, CB, CA} = seg;
        DP = ~dp_lit;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        show(4'hF, 7'h7F, 1'b0, n);
    endtask

    task automatic scan_0123();
        show(4'b0111, 7'h40, 1'b0, 8);
        show(4'b1011, 7'h79, 1'b0, 8);
        show(4'b1101, 7'h24, 1'b1, 8);
        show(4'b1110, 7'h30, 1'b1, 8);
        blank(4);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_digits"}, {16'h0, digits}, 32'h0);
        check({name, "_dp"}, {28'h0, dp}, 32'h0);
        check({name, "_known"}, {28'h0, known}, 32'h0);
        check({name, "_raw"}, raw_seg, 32'hFFFF_FFFF);
        check({name, "_pulses"}, {29'h0, frame_valid, frame_changed, anode_conflict}, 32'h0);
    endtask

    initial begin
        int fv0, fc0;
        reset = 1'b1;
        {AN3, AN2, AN1, AN0} = 4'hF;
        {CG, CF, CE, CD, CC, CB, CA, DP} = 8'hFF;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;
        blank(2);

        // 1: first frame of "0123"
        scan_0123();
        check("t1_digits", {16'h0, digits}, 32'h0000_0123);
        check("t1_dp", {28'h0, dp}, 32'h3);
        check("t1_known", {28'h0, known}, 32'hF);
        check("t1_raw", raw_seg, 32'hC0F9_2430);
        check("t1_fv", fv_cnt, 1);
        check("t1_fc", fc_cnt, 1);

        // 2: identical frames
        scan_0123();
        scan_0123();
        check("t2_fv", fv_cnt, 3);
        check("t2_fc", fc_cnt, 1);
        check("t2_digits", {16'h0, digits}, 32'h0000_0123);

        // 3: digit 2 too short, then completed later
        show(4'b0111, 7'h40, 1'b0, 8);
        show(4'b1011, 7'h79, 1'b0, 3);
        show(4'b1101, 7'h24, 1'b1, 8);
        show(4'b1110, 7'h30, 1'b1, 8);
        blank(4);
        check("t3_no_frame", fv_cnt, 3);
        show(4'b1011, 7'h79, 1'b0, 8);
        blank(4);
        check("t3_frame", fv_cnt, 4);
        check("t3_fc", fc_cnt, 1);

        // 4: two anodes low
        ac_cnt = 0;
        show(4'b1100, 7'h24, 1'b0, 5);
        blank(4);
        check("t4_conflict_cycles", ac_cnt, 5);
        check("t4_fv", fv_cnt, 4);
        check("t4_digits", {16'h0, digits}, 32'h0000_0123);
        check("t4_raw", raw_seg, 32'hC0F9_2430);
        check("t4_dp_known", {24'h0, dp, known}, 32'h3F);

        // 5: unknown pattern on digit 0, also checks the capture latency
        show(4'b1110, 7'h7F, 1'b0, 4);
        check("t5_before_latency", {28'h0, known}, 32'hF);
        show(4'b1110, 7'h7F, 1'b0, 1);
        check("t5_at_latency", {28'h0, known}, 32'hE);
        show(4'b1110, 7'h7F, 1'b0, 3);
        blank(4);
        check("t5_digits", {16'h0, digits}, 32'h0000_0120);
        check("t5_raw0", {24'h0, raw_seg[7:0]}, 32'hFF);
        check("t5_dp", {28'h0, dp}, 32'h2);

        // 6: reset after digits 3 and 2, then a fresh frame
        show(4'b0111, 7'h40, 1'b0, 8);
        show(4'b1011, 7'h79, 1'b0, 8);
        fv0 = fv_cnt;
        fc0 = fc_cnt;
        reset = 1'b1;
        blank(2);
        check_reset_state("t6_rst");
        reset = 1'b0;
        show(4'b0111, 7'h40, 1'b0, 8);
        show(4'b1011, 7'h79, 1'b0, 8);
        show(4'b1101, 7'h24, 1'b1, 8);
        blank(4);
        check("t6_partial", fv_cnt, fv0);
        show(4'b1110, 7'h30, 1'b1, 8);
        blank(4);
        check("t6_fv", fv_cnt, fv0 + 1);
        check("t6_fc", fc_cnt, fc0 + 1);
        check("t6_digits", {16'h0, digits}, 32'h0000_0123);
        check("t6_raw", raw_seg, 32'hC0F9_2430);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
